pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined successor to the team's 4-bit combinational rotator.
- Supports rotate, logical shift and arithmetic shift, in either direction, over WIDTH bits.
- One registered stage per shift-amount bit (log2 decomposition).
- Valid/ready handshake on both sides, so it drops into the datapath between a producer and an ALU result bus.

---
 rtl/pipelined_barrel_shifter_pkg.sv | 17 +
 rtl/pipelined_barrel_shifter_shift_stage.sv | 111 +++++++++++
 rtl/pipelined_barrel_shifter.sv | 87 ++++++++
 tb/tb_pipelined_barrel_shifter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter_pkg
// Description : Shared mode and direction encodings for the pipelined shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package pipelined_barrel_shifter_pkg;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pipelined_barrel_shifter_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One log2 stage: conditional shift by DIST plus stage registers.
//               Optional zero flag under BARREL_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1,
  parameter int SW    = $clog2(WIDTH)
`ifdef BARREL_ZERO_FLAG_EN
  , parameter bit ZFLAG = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_dir,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_amt,
  output logic [1:0]       out_mode,
  output logic             out_dir
`ifdef BARREL_ZERO_FLAG_EN
  , output logic           out_zero
`endif
);

  localparam int            BIT    = $clog2(DIST);
  // Amount bits at or below this stage are consumed; only the higher ones travel on.
  localparam logic [SW-1:0] c_keep = ~SW'(2 * DIST - 1);

  logic [DIST-1:0]  w_fill_r;
  logic [DIST-1:0]  w_fill_l;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_next;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_amt;
  logic [1:0]       r_mode;
  logic             r_dir;

  // Arithmetic right refills with the current MSB, which earlier stages preserve.
  always_comb begin
    w_fill_r = in_data[DIST-1:0];
    w_fill_l = in_data[WIDTH-1:WIDTH-DIST];
    if (in_mode == MODE_LSL) begin
      w_fill_r = '0;
      w_fill_l = '0;
    end else if (in_mode == MODE_ASR) begin
      w_fill_r = {DIST{in_data[WIDTH-1]}};
      w_fill_l = '0;
    end
    if (in_dir == DIR_LEFT) begin
      w_shifted = {in_data[WIDTH-DIST-1:0], w_fill_l};
    end else begin
      w_shifted = {w_fill_r, in_data[WIDTH-1:DIST]};
    end
    w_next = in_amt[BIT] ? w_shifted : in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_mode  <= '0;
      r_dir   <= 1'b0;
    end else if (adv) begin
      r_valid <= in_valid;
      r_data  <= w_next;
      r_amt   <= in_amt & c_keep;
      r_mode  <= in_mode;
      r_dir   <= in_dir;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_amt   = r_amt;
  assign out_mode  = r_mode;
  assign out_dir   = r_dir;

`ifdef BARREL_ZERO_FLAG_EN
  generate
    if (ZFLAG) begin : g_zero
      logic r_zero;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_zero <= 1'b1;
        end else if (adv) begin
          r_zero <= (w_next == '0);
        end
      end
      assign out_zero = r_zero;
    end else begin : g_no_zero
      assign out_zero = 1'b1;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_barrel_shifter
// Description : Pipelined rotate/logical/arithmetic shifter, one stage per amount
//               bit, valid/ready on both sides. Optional out_zero: BARREL_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARREL_ZERO_FLAG_EN
  , output logic           out_zero
`endif
);

  logic             w_adv;
  logic             w_valid [0:SW];
  logic [WIDTH-1:0] w_data  [0:SW];
  logic [SW-1:0]    w_amt   [0:SW];
  logic [1:0]       w_mode  [0:SW];
  logic             w_dir   [0:SW];

  // Whole pipe moves together; a held output freezes every stage.
  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_mode[0]  = in_mode;
  assign w_dir[0]   = in_dir;

`ifdef BARREL_ZERO_FLAG_EN
  logic [SW-1:0] w_zero;
  // Only the final stage computes a real flag; the others tie to 1.
  assign out_zero = &w_zero;
`endif

  generate
    for (genvar k = 0; k < SW; k++) begin : g_stage
      shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k),
        .SW    (SW)
`ifdef BARREL_ZERO_FLAG_EN
        , .ZFLAG (k == SW - 1)
`endif
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .adv       (w_adv),
        .in_valid  (w_valid[k]),
        .in_data   (w_data[k]),
        .in_amt    (w_amt[k]),
        .in_mode   (w_mode[k]),
        .in_dir    (w_dir[k]),
        .out_valid (w_valid[k+1]),
        .out_data  (w_data[k+1]),
        .out_amt   (w_amt[k+1]),
        .out_mode  (w_mode[k+1]),
        .out_dir   (w_dir[k+1])
`ifdef BARREL_ZERO_FLAG_EN
        , .out_zero (w_zero[k])
`endif
      );
    end
  endgenerate

  assign out_valid = w_valid[SW];
  assign out_data  = w_data[SW];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_barrel_shifter
// Description : Directed-vector bench for pipelined_barrel_shifter (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_barrel_shifter;
  import pipelined_barrel_shifter_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_amt;
  logic [1:0]   in_mode;
  logic         in_dir;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef BARREL_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int n_vec;
  int n_err;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARREL_ZERO_FLAG_EN
    , .out_zero (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] d, input logic [2:0] a,
                       input logic [1:0] m, input logic dr);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_mode  = m;
    in_dir   = dr;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    in_dir    = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", W'(out_valid), 8'h00);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ready", W'(in_ready), 8'h01);
`ifdef BARREL_ZERO_FLAG_EN
    chk("rst_zero", W'(out_zero), 8'h01);
`endif
    tick();
    rst = 1'b0;

    // Rotate right 3 on 0x96 with exact latency check.
    drive(8'h96, 3'd3, MODE_ROT, DIR_RIGHT);
    chk("rot3_ready", W'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    chk("rot3_lat1", W'(out_valid), 8'h00);
    tick();
    chk("rot3_lat2", W'(out_valid), 8'h00);
    tick();
    chk("rot3_valid", W'(out_valid), 8'h01);
    chk("rot3_data", out_data, 8'hD2);

    // Amount 0 passes through with full latency.
    drive(8'h96, 3'd0, MODE_ROT, DIR_RIGHT);
    tick();
    in_valid = 1'b0;
    tick();
    chk("amt0_lat2", W'(out_valid), 8'h00);
    tick();
    chk("amt0_valid", W'(out_valid), 8'h01);
    chk("amt0_data", out_data, 8'h96);

    // Back-to-back shift modes.
    drive(8'h96, 3'd2, MODE_LSL, DIR_LEFT);
    tick();
    drive(8'h96, 3'd4, MODE_LSL, DIR_RIGHT);
    tick();
    drive(8'h96, 3'd4, MODE_ASR, DIR_RIGHT);
    tick();
    in_valid = 1'b0;
    chk("lsl2_valid", W'(out_valid), 8'h01);
    chk("lsl2_data", out_data, 8'h58);
    tick();
    chk("lsr4_valid", W'(out_valid), 8'h01);
    chk("lsr4_data", out_data, 8'h09);
    tick();
    chk("asr4_valid", W'(out_valid), 8'h01);
    chk("asr4_data", out_data, 8'hF9);
    tick();
    chk("b2b_drained", W'(out_valid), 8'h00);

    // Backpressure with full pipe plus a pending input beat.
    out_ready = 1'b0;
    drive(8'h81, 3'd1, MODE_ROT, DIR_LEFT);
    tick();
    drive(8'h01, 3'd1, 2'b11, DIR_RIGHT);
    tick();
    drive(8'h80, 3'd1, MODE_LSL, DIR_RIGHT);
    tick();
    drive(8'h80, 3'd1, MODE_ASR, DIR_RIGHT);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", W'(out_valid), 8'h01);
      chk("stall_data", out_data, 8'h03);
      chk("stall_ready", W'(in_ready), 8'h00);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_ready", W'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    chk("mode11_data", out_data, 8'h80);
    tick();
    chk("lsr1_data", out_data, 8'h40);
    tick();
    chk("asr1_valid", W'(out_valid), 8'h01);
    chk("asr1_data", out_data, 8'hC0);
    tick();
    chk("bp_drained", W'(out_valid), 8'h00);

    // Asynchronous reset with a held result in the output stage.
    out_ready = 1'b0;
    drive(8'h55, 3'd1, MODE_ROT, DIR_LEFT);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_data", out_data, 8'hAA);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", W'(out_valid), 8'h00);
    chk("arst_data", out_data, 8'h00);
    chk("arst_ready", W'(in_ready), 8'h01);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_ready", W'(in_ready), 8'h01);
    drive(8'h0F, 3'd2, MODE_LSL, DIR_LEFT);
    tick();
    in_valid = 1'b0;
    chk("post_rst_lat1", W'(out_valid), 8'h00);
    tick();
    chk("post_rst_lat2", W'(out_valid), 8'h00);
    tick();
    chk("post_rst_valid", W'(out_valid), 8'h01);
    chk("post_rst_data", out_data, 8'h3C);

`ifdef BARREL_ZERO_FLAG_EN
    drive(8'h80, 3'd1, MODE_LSL, DIR_LEFT);
    tick();
    drive(8'h80, 3'd1, MODE_ROT, DIR_LEFT);
    tick();
    in_valid = 1'b0;
    tick();
    chk("zf_lsl_data", out_data, 8'h00);
    chk("zf_lsl_zero", W'(out_zero), 8'h01);
    tick();
    chk("zf_rol_data", out_data, 8'h01);
    chk("zf_rol_zero", W'(out_zero), 8'h00);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
